// File: rtl/ste_bus_arbiter.sv
// ste_bus_arbiter: 68000-style BR/BG/BGACK arbiter for the STE system bus.
// Shares the bus between the CPU and NREQ alternate masters. Index 0 is DMA.
// The CPU is parked while an alternate master holds the bus, and the bus goes
// back to the CPU after every tenure.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration, scanning upward from r_rr_ptr
//   undefined -> fixed priority, the lowest index wins (r_rr_ptr is still kept)
module ste_bus_arbiter #(
  parameter  int NREQ          = 2,
  parameter  int GRANT_TIMEOUT = 16,
  parameter  int CPU_SLOTS     = 2,
  localparam int OW            = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk32,
  input  logic            reset,
  input  logic            clk_en,
  input  logic            as_n,
  input  logic [NREQ-1:0] br_n,
  input  logic            bgack_n,
  output logic [NREQ-1:0] bg_n,
  output logic            cpu_hold,
  output logic            bus_free,
  output logic [OW-1:0]   owner,
  output logic            timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_AS = 2'd1,
    GRANT   = 2'd2,
    OWNED   = 2'd3
  } state_t;

  state_t          r_state;
  logic [7:0]      r_timer;
  logic [3:0]      r_slot_cnt;
  logic [OW-1:0]   r_rr_ptr;
  logic [OW-1:0]   r_owner;
  logic [NREQ-1:0] r_bg_n;
  logic            r_cpu_hold;
  logic            r_timeout;

  logic            w_any_req;
  logic [OW-1:0]   w_winner;
  logic [OW-1:0]   w_owner_next;

  // Pick this tick's winner from the active-low request vector
  always_comb begin
    w_any_req = 1'b0;
    w_winner  = '0;
`ifdef ARB_ROUND_ROBIN_EN
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_any_req && !br_n[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_any_req = 1'b1;
        w_winner  = OW'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
`else
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_any_req && !br_n[k]) begin
        w_any_req = 1'b1;
        w_winner  = OW'(k);
      end
    end
`endif
  end

`ifndef ARB_ROUND_ROBIN_EN
  // The pointer is still tracked in fixed-priority builds, but nothing reads it
  logic w_unused_rr;
  assign w_unused_rr = ^r_rr_ptr;
`endif

  // Successor of the current owner, wrapping at NREQ
  always_comb begin
    w_owner_next = r_owner + OW'(1);
    if (int'(r_owner) == NREQ - 1) begin
      w_owner_next = '0;
    end
  end

  // Handshake FSM; all outputs are registered here, timeout self-clears
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_slot_cnt <= '0;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_bg_n     <= '1;
      r_cpu_hold <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (clk_en) begin
        case (r_state)
          IDLE: begin
            if (r_slot_cnt != '0) begin
              r_slot_cnt <= r_slot_cnt - 4'd1;
            end else if (bgack_n && w_any_req) begin
              r_owner    <= w_winner;
              r_cpu_hold <= 1'b1;
              r_state    <= WAIT_AS;
            end
          end
          WAIT_AS: begin
            if (br_n[r_owner]) begin
              r_cpu_hold <= 1'b0;
              r_state    <= IDLE;
            end else if (as_n) begin
              r_bg_n  <= ~(NREQ'(1) << r_owner);
              r_timer <= '0;
              r_state <= GRANT;
            end
          end
          GRANT: begin
            if (!bgack_n) begin
              r_bg_n  <= '1;
              r_state <= OWNED;
            end else if (br_n[r_owner]) begin
              r_bg_n     <= '1;
              r_cpu_hold <= 1'b0;
              r_state    <= IDLE;
            end else if (r_timer == 8'(GRANT_TIMEOUT - 1)) begin
              r_bg_n     <= '1;
              r_timeout  <= 1'b1;
              r_cpu_hold <= 1'b0;
              r_slot_cnt <= 4'(CPU_SLOTS);
              r_state    <= IDLE;
            end else begin
              r_timer <= r_timer + 8'd1;
            end
          end
          OWNED: begin
            if (bgack_n) begin
              r_cpu_hold <= 1'b0;
              r_slot_cnt <= 4'(CPU_SLOTS);
              r_rr_ptr   <= w_owner_next;
              r_state    <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bg_n     = r_bg_n;
  assign cpu_hold = r_cpu_hold;
  assign owner    = r_owner;
  assign timeout  = r_timeout;
  assign bus_free = (&r_bg_n) & bgack_n;

endmodule

// File: tb/tb_ste_bus_arbiter.sv
// Scoreboard bench for ste_bus_arbiter (NREQ=2, GRANT_TIMEOUT=16, CPU_SLOTS=2).
// The stimulus thread pushes the expected grant and timeout events. A monitor
// thread pops them whenever the DUT drops a bg_n or pulses timeout.
module tb_ste_bus_arbiter;
  localparam int N  = 2;
  localparam int GT = 16;
  localparam int CS = 2;

  logic         clk32 = 1'b0;
  logic         reset;
  logic         clk_en = 1'b0;
  logic         as_n;
  logic [N-1:0] br_n;
  logic         bgack_n;
  logic [N-1:0] bg_n;
  logic         cpu_hold;
  logic         bus_free;
  logic [0:0]   owner;
  logic         timeout;

  ste_bus_arbiter #(.NREQ(N), .GRANT_TIMEOUT(GT), .CPU_SLOTS(CS)) dut (
    .clk32(clk32), .reset(reset), .clk_en(clk_en), .as_n(as_n), .br_n(br_n),
    .bgack_n(bgack_n), .bg_n(bg_n), .cpu_hold(cpu_hold), .bus_free(bus_free),
    .owner(owner), .timeout(timeout)
  );

  always #5 clk32 = ~clk32;

  // 8 MHz enable: one clk32 cycle in four, changed away from the active edge
  initial begin
    int ctr = 0;
    forever begin
      @(negedge clk32);
      ctr++;
      clk_en = (ctr % 4 == 0);
    end
  end

  typedef struct { int kind; int idx; } exp_t;   // kind 0 = grant, 1 = timeout
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  int grant_tick = 0;
  int rr = 0;                 // model: next round-robin start
  logic [N-1:0] prev_bg = '1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int grant_vec(input int idx);
    logic [N-1:0] v = '1;
    v[idx] = 1'b0;
    return int'(v);
  endfunction

  // Reference arbitration: the first low request from the scan start
  function automatic int model_winner(input logic [N-1:0] p);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) if (!p[(rr + k) % N]) return (rr + k) % N;
`else
    for (int k = 0; k < N; k++) if (!p[k]) return k;
`endif
    return -1;
  endfunction

  always @(posedge clk32) if (clk_en) tick_cnt++;

  // Monitor: pop an expectation for each grant edge and each timeout pulse
  always @(negedge clk32) begin
    exp_t e;
    if (bg_n != '1 && prev_bg == '1) begin
      grant_tick = tick_cnt;
      if (exp_q.size() == 0) chk("unexpected_grant", int'(bg_n), int'(prev_bg));
      else begin
        e = exp_q.pop_front();
        chk("grant_kind", 0, e.kind);
        chk("grant_vec", int'(bg_n), grant_vec(e.idx));
      end
    end
    if (timeout === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_timeout", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("timeout_kind", 1, e.kind);
        chk("timeout_delay", tick_cnt - grant_tick, GT);
      end
    end
    prev_bg = bg_n;
  end

  task automatic tick();
    do @(posedge clk32); while (clk_en !== 1'b1);
    #1;
  endtask

  task automatic idle_wait();
    br_n = '1; bgack_n = 1'b1;
    repeat (CS + 2) tick();
  endtask

  function automatic logic [N-1:0] rand_req();
    logic [N-1:0] p;
    do p = N'($urandom); while (p == '1);
    return p;
  endfunction

  // Full tenure: park the CPU, grant, BGACK, release
  task automatic tenure_a(input logic [N-1:0] p, input bit keep);
    int w = model_winner(p);
    as_n = 1'b0; br_n = p; bgack_n = 1'b1;
    tick();
    chk("arb_cpu_hold", int'(cpu_hold), 1);
    chk("arb_owner", int'(owner), w);
    chk("no_grant_during_as", int'(bg_n), int'({N{1'b1}}));
    repeat ($urandom_range(0, 2)) tick();
    chk("as_wait_no_grant", int'(bg_n), int'({N{1'b1}}));
    exp_q.push_back('{0, w});
    as_n = 1'b1;
    tick();
    chk("grant_latency", int'(bg_n), grant_vec(w));
    repeat ($urandom_range(0, GT - 3)) tick();
    bgack_n = 1'b0;
    tick();
    chk("owned_bg_released", int'(bg_n), int'({N{1'b1}}));
    chk("owned_bus_free", int'(bus_free), 0);
    repeat ($urandom_range(1, 3)) begin br_n = N'($urandom); tick(); end
    chk("owned_cpu_hold", int'(cpu_hold), 1);
    bgack_n = 1'b1;
    br_n = keep ? p : '1;
    tick();
    chk("release_cpu_hold", int'(cpu_hold), 0);
    rr = (w + 1) % N;
  endtask

  task automatic tenure_timeout(input logic [N-1:0] p);
    int w = model_winner(p);
    as_n = 1'b1; br_n = p; bgack_n = 1'b1;
    exp_q.push_back('{0, w});
    exp_q.push_back('{1, w});
    tick(); tick();
    chk("to_grant", int'(bg_n), grant_vec(w));
    repeat (GT - 1) tick();
    chk("to_still_granted", int'(bg_n), grant_vec(w));
    tick();
    chk("to_withdrawn", int'(bg_n), int'({N{1'b1}}));
    chk("to_cpu_hold", int'(cpu_hold), 0);
    br_n = '1;
  endtask

  task automatic tenure_withdraw(input logic [N-1:0] p);
    int w = model_winner(p);
    as_n = 1'b1; br_n = p; bgack_n = 1'b1;
    exp_q.push_back('{0, w});
    tick(); tick();
    chk("wd_grant", int'(bg_n), grant_vec(w));
    repeat ($urandom_range(0, 3)) tick();
    br_n = '1;
    tick();
    chk("wd_bg", int'(bg_n), int'({N{1'b1}}));
    chk("wd_cpu_hold", int'(cpu_hold), 0);
  endtask

  task automatic abort_wait_as(input logic [N-1:0] p);
    as_n = 1'b0; br_n = p; bgack_n = 1'b1;
    tick();
    chk("abort_hold", int'(cpu_hold), 1);
    br_n = '1;
    tick();
    chk("abort_release", int'(cpu_hold), 0);
    as_n = 1'b1;
    repeat (3) tick();
    chk("abort_no_grant", int'(bg_n), int'({N{1'b1}}));
  endtask

  task automatic foreign_block(input logic [N-1:0] p);
    as_n = 1'b1; br_n = p; bgack_n = 1'b0;
    repeat (3) tick();
    chk("foreign_no_hold", int'(cpu_hold), 0);
    chk("foreign_no_grant", int'(bg_n), int'({N{1'b1}}));
    chk("foreign_bus_free", int'(bus_free), 0);
    br_n = '1; bgack_n = 1'b1;
  endtask

  initial begin
    int n, w2;
    logic [N-1:0] p;
    reset = 1'b1; as_n = 1'b1; br_n = '1; bgack_n = 1'b1;
    repeat (3) @(posedge clk32);
    #1;
    reset = 1'b0;
    tick();
    chk("rst_bg_n", int'(bg_n), int'({N{1'b1}}));
    chk("rst_cpu_hold", int'(cpu_hold), 0);
    chk("rst_bus_free", int'(bus_free), 1);
    chk("rst_owner", int'(owner), 0);
    chk("rst_timeout", int'(timeout), 0);

    // DMA-only request parked behind a CPU cycle
    tenure_a(2'b10, 1'b0);
    idle_wait();

    // Back-to-back tenures with both masters requesting
    tenure_a(2'b00, 1'b1);
    w2 = model_winner(2'b00);
    exp_q.push_back('{0, w2});
    n = 0;
    while (bg_n == '1 && n < 20) begin tick(); n++; end
    chk("b2b_gap_ticks", n, CS + 2);
    chk("b2b_owner", int'(owner), w2);
    bgack_n = 1'b0; tick();
    bgack_n = 1'b1; br_n = '1; tick();
    rr = (w2 + 1) % N;
    idle_wait();

    tenure_timeout(2'b10);
    idle_wait();
    abort_wait_as(2'b10);
    idle_wait();

    // Randomized mix
    for (int i = 0; i < 30; i++) begin
      p = rand_req();
      case ($urandom_range(0, 4))
        0, 1: tenure_a(p, 1'b0);
        2: tenure_timeout(p);
        3: tenure_withdraw(p);
        default: begin
          if ($urandom_range(0, 1) == 0) abort_wait_as(p);
          else foreign_block(p);
        end
      endcase
      idle_wait();
    end

    // Async reset while a master owns the bus
    p = rand_req();
    as_n = 1'b1; br_n = p; bgack_n = 1'b1;
    exp_q.push_back('{0, model_winner(p)});
    tick(); tick();
    bgack_n = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_bg_n", int'(bg_n), int'({N{1'b1}}));
    chk("arst_cpu_hold", int'(cpu_hold), 0);
    chk("arst_bus_free_lo", int'(bus_free), 0);
    chk("arst_owner", int'(owner), 0);
    bgack_n = 1'b1;
    #1;
    chk("arst_bus_free_hi", int'(bus_free), 1);
    br_n = '1;
    tick(); tick();
    reset = 1'b0;
    rr = 0;
    tick();
    tenure_a(2'b00, 1'b0);
    idle_wait();

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the run ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
